// File: rtl/hazard_ctrl.sv
// Hazard and stall controller: resolves data-miss, multi-cycle, load-use and fetch
// stalls into one pipeline stall code, plus flush, PC-enable and halt tracking.
package hazard_pkg;
  typedef enum logic [2:0] {
    NO_STALL    = 3'd0,
    IFID_STALL  = 3'd1,
    IDEX_STALL  = 3'd2,
    EXMEM_STALL = 3'd3,
    FULL_STALL  = 3'd4
  } pipe_stall_t;
endpackage

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              exmem_dREN,
  input  logic              exmem_dWEN,
  input  logic              idex_memread,
  input  logic [4:0]        idex_rd,
  input  logic [4:0]        ifid_rs,
  input  logic [4:0]        ifid_rt,
  input  logic              idex_mc,
  input  logic              branch_taken,
  input  logic              ifid_jump,
  input  logic              memwb_halt,
  output pipe_stall_t       pipe_stall,
  output logic              ifid_FLUSH,
  output logic              idex_FLUSH,
  output logic              pc_WEN,
  output logic              halted,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {RUN, MULTI, HALTED} state_t;

  state_t     state, next_state;
  logic [3:0] mc_cnt, next_mc_cnt;
  logic       dmiss, mc_stall, load_use;

  assign dmiss    = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign mc_stall = ((state == RUN) & idex_mc) | ((state == MULTI) & (mc_cnt != '0));
  assign load_use = idex_memread & (idex_rd != '0) &
                    ((idex_rd == ifid_rs) | (idex_rd == ifid_rt)) & ~branch_taken;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state        <= RUN;
      mc_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      state  <= next_state;
      mc_cnt <= next_mc_cnt;
      if (pipe_stall != NO_STALL && stall_cycles != '1)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

  // The counter only advances on EXMEM_STALL cycles, so FULL_STALL cycles do not
  // eat into the multi-cycle occupancy.
  always_comb begin
    next_state  = state;
    next_mc_cnt = mc_cnt;
    if (memwb_halt) begin
      next_state = HALTED;
    end else begin
      unique case (state)
        RUN: begin
          if (idex_mc && pipe_stall == EXMEM_STALL) begin
            next_state  = MULTI;
            next_mc_cnt = 4'(MC_LAT - 2);
          end
        end
        MULTI: begin
          if (pipe_stall == EXMEM_STALL && mc_cnt != '0)
            next_mc_cnt = mc_cnt - 4'd1;
          if (mc_cnt == '0 && (pipe_stall == NO_STALL || pipe_stall == IFID_STALL ||
                               pipe_stall == IDEX_STALL))
            next_state = RUN;
        end
        HALTED: next_state = HALTED;
        default: next_state = RUN;
      endcase
    end
  end

  always_comb begin
    pipe_stall = NO_STALL;
    if (!nRST || state == HALTED || memwb_halt || dmiss) pipe_stall = FULL_STALL;
    else if (mc_stall)                                   pipe_stall = EXMEM_STALL;
    else if (load_use)                                   pipe_stall = IDEX_STALL;
    else if (!ihit)                                      pipe_stall = IFID_STALL;

    idex_FLUSH = branch_taken & (pipe_stall == NO_STALL || pipe_stall == IFID_STALL);
    ifid_FLUSH = (branch_taken | ifid_jump) & (pipe_stall == NO_STALL);
    pc_WEN     = (pipe_stall == NO_STALL) | ((pipe_stall == IFID_STALL) & branch_taken);
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected outputs are queued as stimulus is driven
// and compared on the following falling edge.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic        CLK, nRST;
  logic        ihit, dhit, exmem_dREN, exmem_dWEN, idex_memread, idex_mc;
  logic        branch_taken, ifid_jump, memwb_halt;
  logic [4:0]  idex_rd, ifid_rs, ifid_rt;
  pipe_stall_t pipe_stall;
  logic        ifid_FLUSH, idex_FLUSH, pc_WEN, halted;
  logic [15:0] stall_cycles;

  hazard_ctrl #(.MC_LAT(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_mc(idex_mc),
    .branch_taken(branch_taken), .ifid_jump(ifid_jump), .memwb_halt(memwb_halt),
    .pipe_stall(pipe_stall), .ifid_FLUSH(ifid_FLUSH), .idex_FLUSH(idex_FLUSH),
    .pc_WEN(pc_WEN), .halted(halted), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic ihit, dhit, dren, dwen, memread, mc, br, jmp, halt;
    logic [4:0] rd, rs, rt;
  } in_t;

  typedef struct {
    pipe_stall_t stall;
    logic        ifid_f, idex_f, pcw, hlt;
  } exp_t;

  exp_t        q[$];
  int          nerr = 0;
  int          nchk = 0;
  logic [15:0] exp_sc = '0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation time limit reached, expected finish earlier");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t i;
    i = '{ihit: 1'b1, dhit: 1'b0, dren: 1'b0, dwen: 1'b0, memread: 1'b0, mc: 1'b0,
          br: 1'b0, jmp: 1'b0, halt: 1'b0, rd: 5'd0, rs: 5'd0, rt: 5'd0};
    return i;
  endfunction

  task automatic apply(input in_t i);
    ihit = i.ihit; dhit = i.dhit; exmem_dREN = i.dren; exmem_dWEN = i.dwen;
    idex_memread = i.memread; idex_mc = i.mc; branch_taken = i.br;
    ifid_jump = i.jmp; memwb_halt = i.halt;
    idex_rd = i.rd; ifid_rs = i.rs; ifid_rt = i.rt;
  endtask

  task automatic cyc(input in_t i, input pipe_stall_t s, input logic eif, input logic eid,
                     input logic epc, input logic eh);
    exp_t e;
    @(posedge CLK);
    #1;
    apply(i);
    e = '{stall: s, ifid_f: eif, idex_f: eid, pcw: epc, hlt: eh};
    q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check_val("pipe_stall", 32'(pipe_stall), 32'(e.stall));
      check_val("ifid_FLUSH", 32'(ifid_FLUSH), 32'(e.ifid_f));
      check_val("idex_FLUSH", 32'(idex_FLUSH), 32'(e.idex_f));
      check_val("pc_WEN", 32'(pc_WEN), 32'(e.pcw));
      check_val("halted", 32'(halted), 32'(e.hlt));
      check_val("stall_cycles", 32'(stall_cycles), 32'(exp_sc));
      if (e.stall != NO_STALL && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    end
  end

  task automatic do_reset();
    while (q.size() > 0) @(negedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    apply(idle());
    exp_sc = '0;
    #2;
    check_val("rst_stall", 32'(pipe_stall), 32'(FULL_STALL));
    check_val("rst_pcwen", 32'(pc_WEN), 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);
    check_val("rst_scnt", 32'(stall_cycles), 32'd0);
    #1;
    nRST = 1'b1;
  endtask

  in_t i;

  initial begin
    nRST = 1'b0;
    i = idle();
    i.br = 1'b1; i.jmp = 1'b1;
    apply(i);
    #3;
    check_val("rst0_stall", 32'(pipe_stall), 32'(FULL_STALL));
    check_val("rst0_ifidf", 32'(ifid_FLUSH), 32'd0);
    check_val("rst0_idexf", 32'(idex_FLUSH), 32'd0);
    check_val("rst0_pcwen", 32'(pc_WEN), 32'd0);
    check_val("rst0_halted", 32'(halted), 32'd0);
    check_val("rst0_scnt", 32'(stall_cycles), 32'd0);
    #4;
    nRST = 1'b1;

    // Load-use and fetch/branch combinations
    cyc(idle(), NO_STALL, 0, 0, 1, 0);
    i = idle(); i.memread = 1; i.rd = 5'd5; i.rs = 5'd5;
    cyc(i, IDEX_STALL, 0, 0, 0, 0);
    i = idle(); i.memread = 1; i.rd = 5'd7; i.rt = 5'd7; i.rs = 5'd3;
    cyc(i, IDEX_STALL, 0, 0, 0, 0);
    i = idle(); i.memread = 1; i.rd = 5'd0; i.rs = 5'd0;
    cyc(i, NO_STALL, 0, 0, 1, 0);
    i = idle(); i.memread = 1; i.rd = 5'd5; i.rs = 5'd6; i.rt = 5'd4;
    cyc(i, NO_STALL, 0, 0, 1, 0);
    i = idle(); i.memread = 1; i.rd = 5'd5; i.rs = 5'd5; i.br = 1;
    cyc(i, NO_STALL, 1, 1, 1, 0);
    i = idle(); i.br = 1;
    cyc(i, NO_STALL, 1, 1, 1, 0);
    i = idle(); i.br = 1; i.ihit = 0;
    cyc(i, IFID_STALL, 0, 1, 1, 0);
    i = idle(); i.jmp = 1;
    cyc(i, NO_STALL, 1, 0, 1, 0);
    i = idle(); i.jmp = 1; i.ihit = 0;
    cyc(i, IFID_STALL, 0, 0, 0, 0);
    i = idle(); i.br = 1; i.dren = 1;
    cyc(i, FULL_STALL, 0, 0, 0, 0);
    i = idle(); i.dwen = 1; i.ihit = 0;
    cyc(i, FULL_STALL, 0, 0, 0, 0);
    i = idle(); i.dren = 1; i.dhit = 1;
    cyc(i, NO_STALL, 0, 0, 1, 0);
    i = idle(); i.memread = 1; i.rd = 5'd9; i.rs = 5'd9; i.ihit = 0;
    cyc(i, IDEX_STALL, 0, 0, 0, 0);

    // Multi-cycle op, MC_LAT=4: three EXMEM stalls then release
    do_reset();
    i = idle(); i.mc = 1;
    cyc(i, EXMEM_STALL, 0, 0, 0, 0);
    i.memread = 1; i.rd = 5'd2; i.rs = 5'd2;
    cyc(i, EXMEM_STALL, 0, 0, 0, 0);
    i = idle(); i.mc = 1;
    cyc(i, EXMEM_STALL, 0, 0, 0, 0);
    cyc(i, NO_STALL, 0, 0, 1, 0);
    cyc(idle(), NO_STALL, 0, 0, 1, 0);
    while (q.size() > 0) @(negedge CLK);
    check_val("mc_scnt", 32'(stall_cycles), 32'd3);

    // Multi-cycle op with a two-cycle data miss in the second stall cycle
    i = idle(); i.mc = 1;
    cyc(i, EXMEM_STALL, 0, 0, 0, 0);
    i.dren = 1;
    cyc(i, FULL_STALL, 0, 0, 0, 0);
    cyc(i, FULL_STALL, 0, 0, 0, 0);
    i.dren = 0;
    cyc(i, EXMEM_STALL, 0, 0, 0, 0);
    cyc(i, EXMEM_STALL, 0, 0, 0, 0);
    cyc(i, NO_STALL, 0, 0, 1, 0);
    cyc(idle(), NO_STALL, 0, 0, 1, 0);

    // Reset abandons MULTI
    i = idle(); i.mc = 1;
    cyc(i, EXMEM_STALL, 0, 0, 0, 0);
    do_reset();
    cyc(idle(), NO_STALL, 0, 0, 1, 0);

    // Halt is absorbing until reset
    i = idle(); i.halt = 1;
    cyc(i, FULL_STALL, 0, 0, 0, 0);
    cyc(idle(), FULL_STALL, 0, 0, 0, 1);
    i = idle(); i.br = 1;
    cyc(i, FULL_STALL, 0, 0, 0, 1);
    cyc(idle(), FULL_STALL, 0, 0, 0, 1);
    do_reset();
    cyc(idle(), NO_STALL, 0, 0, 1, 0);

    // Saturation of the stall counter under a long data miss
    i = idle(); i.dren = 1;
    for (int unsigned n = 0; n < 70000; n++)
      cyc(i, FULL_STALL, 0, 0, 0, 0);
    cyc(idle(), NO_STALL, 0, 0, 1, 0);
    while (q.size() > 0) @(negedge CLK);
    check_val("sat_scnt", 32'(stall_cycles), 32'hFFFF);
    do_reset();
    check_val("post_rst_scnt", 32'(stall_cycles), 32'd0);
    cyc(idle(), NO_STALL, 0, 0, 1, 0);
    while (q.size() > 0) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
